// File: rtl/dac_spi_slave_model.sv
// SPI responder model for LTC2624-style 32-bit DAC command frames.
// Oversamples sclk/cs_n/mosi on clk, deserializes each frame and decodes it
// into per-channel input/DAC registers and power-down flags. The previous
// frame is echoed on miso so a master can confirm what it sent.
module dac_spi_slave_model #(
  parameter int FRAME_BITS  = 32,
  parameter int DATA_BITS   = 12,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sclk,
  input  logic                          cs_n,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          frame_valid,
  output logic                          frame_error,
  output logic [FRAME_BITS-1:0]         last_word,
  output logic [NUM_CH*DATA_BITS-1:0]   dac_out,
  output logic [NUM_CH-1:0]             pwr_down
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } state_e;

  // Bit counter saturates here so very long frames cannot wrap back to a valid count
  localparam logic [5:0] CNT_MAX   = 6'd63;
  localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);

  // Synchronizer chains plus one-cycle-delayed copies used for edge detection
  logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
  logic                   sclkPrev_q, csPrev_q;
  logic                   sclkS, csS, mosiS;
  logic                   sclkRise, sclkFall, csRise, csFall;

  state_e                               state_q, state_d;
  logic [5:0]                           bitCnt_q, bitCnt_d;
  logic [FRAME_BITS-1:0]                shReg_q, shReg_d;
  logic [FRAME_BITS-1:0]                echo_q, echo_d;
  logic [FRAME_BITS-1:0]                lastWord_q, lastWord_d;
  logic                                 miso_q, miso_d;
  logic                                 frameValid_q, frameValid_d;
  logic                                 frameError_q, frameError_d;
  logic [NUM_CH-1:0][DATA_BITS-1:0]     inReg_q, inReg_d;
  logic [NUM_CH-1:0][DATA_BITS-1:0]     dac_q, dac_d;
  logic [NUM_CH-1:0]                    pwrDown_q, pwrDown_d;

  logic [3:0]            cmd;
  logic [3:0]            addr;
  logic [DATA_BITS-1:0]  data;
  logic [NUM_CH-1:0]     chSel;

  // cs_n sync resets low so a cs_n held low through reset never looks like a fresh fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclkSync_q <= '0;
      csSync_q   <= '0;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_n};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
      sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
      csPrev_q   <= csSync_q[SYNC_STAGES-1];
    end
  end

  assign sclkS    = sclkSync_q[SYNC_STAGES-1];
  assign csS      = csSync_q[SYNC_STAGES-1];
  assign mosiS    = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  assign csRise   = csS & ~csPrev_q;
  assign csFall   = ~csS & csPrev_q;

  assign cmd  = shReg_q[23:20];
  assign addr = shReg_q[19:16];
  assign data = shReg_q[4 +: DATA_BITS];

  // Channel select: 4'hF broadcasts, out-of-range addresses select nothing
  always_comb begin
    chSel = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      chSel[ch] = (addr == 4'hF) || (int'(addr) == ch);
    end
  end

  // Next-state logic: frame capture, miso echo, and command decode
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    shReg_d      = shReg_q;
    echo_d       = echo_q;
    lastWord_d   = lastWord_q;
    miso_d       = miso_q;
    frameValid_d = 1'b0;
    frameError_d = 1'b0;
    inReg_d      = inReg_q;
    dac_d        = dac_q;
    pwrDown_d    = pwrDown_q;

    case (state_q)
      IDLE: begin
        if (csFall) begin
          bitCnt_d = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (sclkRise) begin
          shReg_d = {shReg_q[FRAME_BITS-2:0], mosiS};
          if (bitCnt_q != CNT_MAX) begin
            bitCnt_d = bitCnt_q + 6'd1;
          end
        end
        if (sclkFall) begin
          miso_d = echo_q[FRAME_BITS-1];
          echo_d = {echo_q[FRAME_BITS-2:0], 1'b0};
        end
        if (csRise) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        lastWord_d = shReg_q;
        echo_d     = shReg_q;
        state_d    = IDLE;
        if (bitCnt_q == FRAME_CNT) begin
          frameValid_d = 1'b1;
          for (int ch = 0; ch < NUM_CH; ch++) begin
            case (cmd)
              4'b0000: begin
                if (chSel[ch]) inReg_d[ch] = data;
              end
              4'b0001: begin
                if (chSel[ch]) begin
                  dac_d[ch]     = inReg_q[ch];
                  pwrDown_d[ch] = 1'b0;
                end
              end
              4'b0010: begin
                if (chSel[ch]) begin
                  inReg_d[ch] = data;
                  dac_d[ch]   = data;
                end else begin
                  dac_d[ch]   = inReg_q[ch];
                end
              end
              4'b0011: begin
                if (chSel[ch]) begin
                  inReg_d[ch]   = data;
                  dac_d[ch]     = data;
                  pwrDown_d[ch] = 1'b0;
                end
              end
              4'b0100: begin
                if (chSel[ch]) pwrDown_d[ch] = 1'b1;
              end
              default: ;
            endcase
          end
        end else begin
          frameError_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      shReg_q      <= '0;
      echo_q       <= '0;
      lastWord_q   <= '0;
      miso_q       <= 1'b0;
      frameValid_q <= 1'b0;
      frameError_q <= 1'b0;
      inReg_q      <= '0;
      dac_q        <= '0;
      pwrDown_q    <= '0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      shReg_q      <= shReg_d;
      echo_q       <= echo_d;
      lastWord_q   <= lastWord_d;
      miso_q       <= miso_d;
      frameValid_q <= frameValid_d;
      frameError_q <= frameError_d;
      inReg_q      <= inReg_d;
      dac_q        <= dac_d;
      pwrDown_q    <= pwrDown_d;
    end
  end

  assign miso        = miso_q;
  assign frame_valid = frameValid_q;
  assign frame_error = frameError_q;
  assign last_word   = lastWord_q;
  assign dac_out     = dac_q;
  assign pwr_down    = pwrDown_q;

endmodule

// File: tb/tb_dac_spi_slave_model.sv
// Directed bench for dac_spi_slave_model: a table of command frames with
// hand-computed DAC/power-down results, plus hand sequences for the
// coincident sclk/cs_n edge, mid-frame reset and cs_n low out of reset.
module tb_dac_spi_slave_model;

  localparam int FRAME_BITS  = 32;
  localparam int DATA_BITS   = 12;
  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;
  localparam int LAT         = SYNC_STAGES + 2;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        sclk;
  logic                        cs_n;
  logic                        mosi;
  logic                        miso;
  logic                        frame_valid;
  logic                        frame_error;
  logic [FRAME_BITS-1:0]       last_word;
  logic [NUM_CH*DATA_BITS-1:0] dac_out;
  logic [NUM_CH-1:0]           pwr_down;

  int checks   = 0;
  int failures = 0;
  int validCnt = 0;
  int errorCnt = 0;

  logic [31:0] modelSh  = '0;
  logic [31:0] prevEcho = '0;

  typedef struct {
    logic [63:0] word;
    int          nbits;
    bit          expValid;
    logic [47:0] expDac;
    logic [3:0]  expPd;
  } vec_t;

  vec_t vecs[19];

  dac_spi_slave_model #(
    .FRAME_BITS (FRAME_BITS),
    .DATA_BITS  (DATA_BITS),
    .NUM_CH     (NUM_CH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .last_word  (last_word),
    .dac_out    (dac_out),
    .pwr_down   (pwr_down)
  );

  always #5 clk = ~clk;

  // Count every decode pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_valid) validCnt++;
    if (frame_error) errorCnt++;
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Send the low nbits of word MSB first; capture miso after each sclk fall
  task automatic applyStimulus(input logic [63:0] word, input int nbits, input bit riseWithCs,
                               output int latency, output logic [31:0] echoBits, output int echoLen);
    echoBits = '0;
    echoLen  = 0;
    cs_n = 1'b0;
    waitClk(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = word[i];
      waitClk(HALF);
      modelSh = {modelSh[30:0], word[i]};
      if (riseWithCs && i == 0) begin
        sclk = 1'b1;
        cs_n = 1'b1;
      end else begin
        sclk = 1'b1;
        waitClk(HALF);
        sclk = 1'b0;
        waitClk(HALF);
        if (echoLen < 32) begin
          echoBits[31-echoLen] = miso;
          echoLen++;
        end
      end
    end
    cs_n = 1'b1;
    latency = 0;
    while (latency < 20 && !(frame_valid || frame_error)) begin
      @(posedge clk);
      #1;
      latency++;
    end
    sclk = 1'b0;
  endtask

  // Run one frame and check pulse, latency, registers, last_word and echo
  task automatic runFrame(input string tag, input logic [63:0] word, input int nbits, input bit riseWithCs,
                          input bit expValid, input logic [47:0] expDac, input logic [3:0] expPd);
    int          lat;
    int          vC;
    int          eC;
    int          eLen;
    logic [31:0] eBits;
    logic [31:0] mask;
    vC = validCnt;
    eC = errorCnt;
    applyStimulus(word, nbits, riseWithCs, lat, eBits, eLen);
    waitClk(1);
    checkOutput({tag, " pulse_width"}, {62'd0, frame_valid, frame_error}, 64'd0);
    waitClk(3);
    mask = 32'hFFFF_FFFF << (32 - eLen);
    checkOutput({tag, " latency"}, 64'(lat), 64'(LAT));
    checkOutput({tag, " valid_pulses"}, 64'(validCnt - vC), 64'(expValid));
    checkOutput({tag, " error_pulses"}, 64'(errorCnt - eC), 64'(!expValid));
    checkOutput({tag, " dac_out"}, 64'(dac_out), 64'(expDac));
    checkOutput({tag, " pwr_down"}, 64'(pwr_down), 64'(expPd));
    checkOutput({tag, " last_word"}, 64'(last_word), 64'(modelSh));
    checkOutput({tag, " miso_echo"}, 64'(eBits & mask), 64'(prevEcho & mask));
    prevEcho = modelSh;
    waitClk(4);
  endtask

  initial begin
    int vC;
    int eC;

    vecs[0]  = '{64'h0030_ABC0,    32, 1'b1, 48'h000_000_000_ABC, 4'b0000};
    vecs[1]  = '{64'h0001_1230,    32, 1'b1, 48'h000_000_000_ABC, 4'b0000};
    vecs[2]  = '{64'h0011_0000,    32, 1'b1, 48'h000_000_123_ABC, 4'b0000};
    vecs[3]  = '{64'h003F_FFF0,    32, 1'b1, 48'hFFF_FFF_FFF_FFF, 4'b0000};
    vecs[4]  = '{64'h0042_0000,    32, 1'b1, 48'hFFF_FFF_FFF_FFF, 4'b0100};
    vecs[5]  = '{64'h0030_1230,    31, 1'b0, 48'hFFF_FFF_FFF_FFF, 4'b0100};
    vecs[6]  = '{64'h1_0030_5670,  33, 1'b0, 48'hFFF_FFF_FFF_FFF, 4'b0100};
    vecs[7]  = '{64'h0000_1110,    32, 1'b1, 48'hFFF_FFF_FFF_FFF, 4'b0100};
    vecs[8]  = '{64'h0022_2220,    32, 1'b1, 48'hFFF_222_FFF_111, 4'b0100};
    vecs[9]  = '{64'h0032_4560,    32, 1'b1, 48'hFFF_456_FFF_111, 4'b0000};
    vecs[10] = '{64'h0035_7770,    32, 1'b1, 48'hFFF_456_FFF_111, 4'b0000};
    vecs[11] = '{64'h00F3_0000,    32, 1'b1, 48'hFFF_456_FFF_111, 4'b0000};
    vecs[12] = '{64'h0041_0000,    32, 1'b1, 48'hFFF_456_FFF_111, 4'b0010};
    vecs[13] = '{64'h0011_0000,    32, 1'b1, 48'hFFF_456_FFF_111, 4'b0000};
    vecs[14] = '{64'h0050_1230,    32, 1'b1, 48'hFFF_456_FFF_111, 4'b0000};
    vecs[15] = '{64'h004F_0000,    32, 1'b1, 48'hFFF_456_FFF_111, 4'b1111};
    vecs[16] = '{64'h001F_0000,    32, 1'b1, 48'hFFF_456_FFF_111, 4'b0000};
    vecs[17] = '{64'h0000_00A5,     8, 1'b0, 48'hFFF_456_FFF_111, 4'b0000};
    vecs[18] = '{64'hAB_0030_0FF0, 40, 1'b0, 48'hFFF_456_FFF_111, 4'b0000};

    reset = 1'b1;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    waitClk(3);
    checkOutput("reset flags", {61'd0, miso, frame_valid, frame_error}, 64'd0);
    checkOutput("reset last_word", 64'(last_word), 64'd0);
    checkOutput("reset dac_out", 64'(dac_out), 64'd0);
    checkOutput("reset pwr_down", 64'(pwr_down), 64'd0);
    reset = 1'b0;
    waitClk(5);

    for (int i = 0; i < 19; i++) begin
      runFrame($sformatf("v%0d", i), vecs[i].word, vecs[i].nbits, 1'b0,
               vecs[i].expValid, vecs[i].expDac, vecs[i].expPd);
    end

    // Final sclk rise lands in the same cycle as the cs_n rise
    runFrame("coincident", 64'h0031_2340, 32, 1'b1, 1'b1, 48'hFFF_456_234_111, 4'b0000);

    // Reset after 16 bits of a frame, with cs_n still low
    cs_n = 1'b0;
    waitClk(HALF);
    for (int i = 31; i >= 16; i--) begin
      mosi = vecs[0].word[i] ^ 1'b1;
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(HALF);
      sclk = 1'b0;
      waitClk(HALF);
    end
    reset = 1'b1;
    waitClk(2);
    checkOutput("midreset flags", {61'd0, miso, frame_valid, frame_error}, 64'd0);
    checkOutput("midreset last_word", 64'(last_word), 64'd0);
    checkOutput("midreset dac_out", 64'(dac_out), 64'd0);
    checkOutput("midreset pwr_down", 64'(pwr_down), 64'd0);
    modelSh  = '0;
    prevEcho = '0;
    reset = 1'b0;
    waitClk(5);

    // cs_n low out of reset: clocks and the following cs_n rise must be ignored
    vC = validCnt;
    eC = errorCnt;
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(HALF);
      sclk = 1'b0;
      waitClk(HALF);
    end
    cs_n = 1'b1;
    waitClk(12);
    checkOutput("stale_cs pulses", 64'((validCnt - vC) + (errorCnt - eC)), 64'd0);
    checkOutput("stale_cs last_word", 64'(last_word), 64'd0);
    mosi = 1'b0;

    runFrame("post_reset", 64'h0030_5550, 32, 1'b0, 1'b1, 48'h000_000_000_555, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
